// File: rtl/instr_loader_encoder_pkg.sv
// Shared types and RV32I opcode constants for the instruction loader/encoder.
package instr_loader_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } enc_fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

    localparam logic [6:0] opcode_r_type = 7'b0110011;
    localparam logic [6:0] opcode_i_load = 7'b0000011;
    localparam logic [6:0] opcode_i_alu  = 7'b0010011;
    localparam logic [6:0] opcode_i_jalr = 7'b1100111;
    localparam logic [6:0] opcode_s_type = 7'b0100011;
    localparam logic [6:0] opcode_b_type = 7'b1100011;
    localparam logic [6:0] opcode_lui    = 7'b0110111;
    localparam logic [6:0] opcode_auipc  = 7'b0010111;
    localparam logic [6:0] opcode_jal    = 7'b1101111;

endpackage

// File: rtl/instr_loader_encoder_if.sv
// Field-bundle handshake plus instruction-memory write port.
interface instr_loader_encoder_if;
    import instr_loader_encoder_pkg::*;

    logic        in_valid;
    logic        in_ready;
    enc_fmt_t    in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        in_last;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    // Producer of bundles / consumer of memory writes
    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    // Encoder side
    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/instr_loader_encoder_field_pack.sv
// Combinational RV32I field packer: decoded fields -> 32-bit word plus legality flag.
module instr_field_pack
    import instr_loader_encoder_pkg::*;
(
    input  enc_fmt_t    fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word_c,
    output logic        legal_c
);

    logic imm12_ok;
    logic imm13_ok;
    logic imm21_ok;

    // Sign-extension checks: every bit above the encodable field must match its sign bit
    always_comb begin
        imm12_ok = (&imm[31:11]) | ~(|imm[31:11]);
        imm13_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
        imm21_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
    end

    always_comb begin
        word_c  = '0;
        legal_c = 1'b0;
        case (fmt)
            FMT_R: begin
                word_c  = {funct7, rs2, rs1, funct3, rd, opcode};
                legal_c = (opcode == opcode_r_type);
            end
            FMT_I: begin
                word_c  = {imm[11:0], rs1, funct3, rd, opcode};
                legal_c = imm12_ok & ((opcode == opcode_i_load) |
                                      (opcode == opcode_i_alu)  |
                                      (opcode == opcode_i_jalr));
            end
            FMT_S: begin
                word_c  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal_c = imm12_ok & (opcode == opcode_s_type);
            end
            FMT_B: begin
                word_c  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal_c = imm13_ok & (opcode == opcode_b_type);
            end
            FMT_U: begin
                word_c  = {imm[31:12], rd, opcode};
                legal_c = (imm[11:0] == 12'd0) &
                          ((opcode == opcode_lui) | (opcode == opcode_auipc));
            end
            FMT_J: begin
                word_c  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal_c = imm21_ok & (opcode == opcode_jal);
            end
            default: begin
                word_c  = '0;
                legal_c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_loader_encoder.sv
// Program loader: accepts field bundles, encodes them and writes legal words to IMEM sequentially.
module instr_loader_encoder
    import instr_loader_encoder_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    instr_loader_encoder_if.slave         bus,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [7:0]                    err_count,
    output logic [$clog2(IMEM_DEPTH):0]   words_written
);

    localparam int unsigned CW = $clog2(IMEM_DEPTH) + 1;

    load_state_t state_q, state_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    err_count_q, err_count_d;
    logic [CW-1:0] words_q, words_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic [31:0] word_c;
    logic        legal_c;
    logic        accept_c;

    instr_field_pack u_pack (
        .fmt    (bus.in_fmt),
        .opcode (bus.in_opcode),
        .rd     (bus.in_rd),
        .rs1    (bus.in_rs1),
        .rs2    (bus.in_rs2),
        .funct3 (bus.in_funct3),
        .funct7 (bus.in_funct7),
        .imm    (bus.in_imm),
        .word_c (word_c),
        .legal_c(legal_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            words_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            words_q     <= words_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Next state, counters and write port; a start pulse always wins over a same-cycle bundle
    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        err_count_d = err_count_q;
        words_d     = words_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        accept_c    = ready_q & bus.in_valid;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    err_d       = 1'b0;
                    err_count_d = '0;
                    words_d     = '0;
                end
            end
            ST_LOAD: begin
                if (start) begin
                    err_d       = 1'b0;
                    err_count_d = '0;
                    words_d     = '0;
                end else if (accept_c) begin
                    if (!legal_c || (words_q == CW'(IMEM_DEPTH))) begin
                        err_d       = 1'b1;
                        err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = 32'({words_q, 2'b00});
                        wdata_d = word_c;
                        words_d = words_q + CW'(1);
                    end
                    // Overflow ends the session just like in_last does
                    if (bus.in_last || (legal_c && (words_q == CW'(IMEM_DEPTH)))) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_LOAD);
        busy_d  = (state_d == ST_LOAD);
        done_d  = (state_d == ST_DONE);
    end

    assign bus.in_ready   = ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign err_count      = err_count_q;
    assign words_written  = words_q;

endmodule

// File: tb/tb_instr_loader_encoder.sv
// Directed bench: two encoder instances (depth 256 and depth 4) driven with the same bundles.
module tb_instr_loader_encoder;
    import instr_loader_encoder_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    enc_fmt_t    in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        in_last;

    logic       busy_a, done_a, err_a;
    logic [7:0] errc_a;
    logic [8:0] ww_a;
    logic       busy_b, done_b, err_b;
    logic [7:0] errc_b;
    logic [2:0] ww_b;

    int n_assert = 0;
    int n_fail   = 0;

    instr_loader_encoder_if if_a ();
    instr_loader_encoder_if if_b ();

    assign if_a.in_valid  = in_valid;   assign if_b.in_valid  = in_valid;
    assign if_a.in_fmt    = in_fmt;     assign if_b.in_fmt    = in_fmt;
    assign if_a.in_opcode = in_opcode;  assign if_b.in_opcode = in_opcode;
    assign if_a.in_rd     = in_rd;      assign if_b.in_rd     = in_rd;
    assign if_a.in_rs1    = in_rs1;     assign if_b.in_rs1    = in_rs1;
    assign if_a.in_rs2    = in_rs2;     assign if_b.in_rs2    = in_rs2;
    assign if_a.in_funct3 = in_funct3;  assign if_b.in_funct3 = in_funct3;
    assign if_a.in_funct7 = in_funct7;  assign if_b.in_funct7 = in_funct7;
    assign if_a.in_imm    = in_imm;     assign if_b.in_imm    = in_imm;
    assign if_a.in_last   = in_last;    assign if_b.in_last   = in_last;

    instr_loader_encoder #(.IMEM_DEPTH(256)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(if_a),
        .busy(busy_a), .done(done_a), .err(err_a), .err_count(errc_a), .words_written(ww_a)
    );

    instr_loader_encoder #(.IMEM_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(if_b),
        .busy(busy_b), .done(done_b), .err(err_b), .err_count(errc_b), .words_written(ww_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input enc_fmt_t f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic last);
        in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic addi(input logic [31:0] imm, input logic last);
        send(FMT_I, opcode_i_alu, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imm, last);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic chk_write_a(input string tag, input logic [31:0] addr, input logic [31:0] data);
        chk({tag, ".we"},    32'(if_a.imem_we), 32'd1);
        chk({tag, ".addr"},  if_a.imem_addr, addr);
        chk({tag, ".wdata"}, if_a.imem_wdata, data);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_fmt = FMT_R; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        chk("rst.busy",  32'(busy_a), 32'd0);
        chk("rst.done",  32'(done_a), 32'd0);
        chk("rst.err",   32'(err_a), 32'd0);
        chk("rst.errc",  32'(errc_a), 32'd0);
        chk("rst.ww",    32'(ww_a), 32'd0);
        chk("rst.ready", 32'(if_a.in_ready), 32'd0);
        chk("rst.we",    32'(if_a.imem_we), 32'd0);
        chk("rst.addr",  if_a.imem_addr, 32'd0);
        chk("rst.wdata", if_a.imem_wdata, 32'd0);

        rst_n = 1'b1;
        // A bundle offered in IDLE is ignored
        addi(32'd5, 1'b1);
        chk("idle.we",   32'(if_a.imem_we), 32'd0);
        chk("idle.busy", 32'(busy_a), 32'd0);

        // addi x1,x0,5 with last
        pulse_start();
        chk("t1.busy",  32'(busy_a), 32'd1);
        chk("t1.ready", 32'(if_a.in_ready), 32'd1);
        addi(32'd5, 1'b1);
        chk_write_a("t1", 32'd0, 32'h0050_0093);
        chk("t1.done", 32'(done_a), 32'd1);
        chk("t1.busy2", 32'(busy_a), 32'd0);
        chk("t1.err",  32'(err_a), 32'd0);
        chk("t1.ww",   32'(ww_a), 32'd1);
        idle_cycle();
        chk("t1.hold.we",    32'(if_a.imem_we), 32'd0);
        chk("t1.hold.wdata", if_a.imem_wdata, 32'h0050_0093);

        // sw x2,8(x1) then beq x0,x0,-4 back to back
        pulse_start();
        send(FMT_S, opcode_s_type, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0);
        chk_write_a("t2.sw", 32'd0, 32'h0020_A423);
        chk("t2.sw.done", 32'(done_a), 32'd0);
        send(FMT_B, opcode_b_type, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1);
        chk_write_a("t2.beq", 32'd4, 32'hFE00_0EE3);
        chk("t2.done", 32'(done_a), 32'd1);
        chk("t2.ww",   32'(ww_a), 32'd2);

        // lui x5,0x12345 then jal x1,0x800
        pulse_start();
        chk("t3.ww.clear", 32'(ww_a), 32'd0);
        send(FMT_U, opcode_lui, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0);
        chk_write_a("t3.lui", 32'd0, 32'h1234_52B7);
        send(FMT_J, opcode_jal, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 1'b1);
        chk_write_a("t3.jal", 32'd4, 32'h0010_00EF);
        chk("t3.ww", 32'(ww_a), 32'd2);

        // Illegal bundles are skipped and counted
        pulse_start();
        addi(32'd2048, 1'b0);
        chk("t4.i.we",   32'(if_a.imem_we), 32'd0);
        chk("t4.i.err",  32'(err_a), 32'd1);
        chk("t4.i.errc", 32'(errc_a), 32'd1);
        send(FMT_B, opcode_b_type, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0);
        chk("t4.b.we",   32'(if_a.imem_we), 32'd0);
        chk("t4.b.errc", 32'(errc_a), 32'd2);
        send(FMT_R, opcode_lui, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b0);
        chk("t4.r.we",   32'(if_a.imem_we), 32'd0);
        chk("t4.r.errc", 32'(errc_a), 32'd3);
        addi(32'd5, 1'b1);
        chk_write_a("t4.addi", 32'd0, 32'h0050_0093);
        chk("t4.err",  32'(err_a), 32'd1);
        chk("t4.errc", 32'(errc_a), 32'd3);
        chk("t4.ww",   32'(ww_a), 32'd1);
        pulse_start();
        chk("t4.clr.err",  32'(err_a), 32'd0);
        chk("t4.clr.errc", 32'(errc_a), 32'd0);

        // Immediate range boundaries and undefined format
        send(FMT_I, opcode_i_alu, 5'd3, 5'd3, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0);
        chk_write_a("t5.addim1", 32'd0, 32'hFFF1_8193);
        addi(32'hFFFF_F800, 1'b0);
        chk_write_a("t5.addimin", 32'd4, 32'h8000_0093);
        send(enc_fmt_t'(3'd7), opcode_r_type, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0);
        chk("t5.fmt7.we",   32'(if_a.imem_we), 32'd0);
        chk("t5.fmt7.errc", 32'(errc_a), 32'd1);
        send(FMT_J, opcode_jal, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000, 1'b0);
        chk_write_a("t5.jalmin", 32'd8, 32'h8000_006F);
        send(FMT_J, opcode_jal, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 1'b0);
        chk("t5.jalovr.we", 32'(if_a.imem_we), 32'd0);
        send(FMT_U, opcode_lui, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 1'b0);
        chk("t5.ulow.we",   32'(if_a.imem_we), 32'd0);
        chk("t5.errc",      32'(errc_a), 32'd3);
        chk("t5.ww",        32'(ww_a), 32'd3);

        // Start in LOAD drops the same-cycle bundle and restarts
        start = 1'b1;
        addi(32'd5, 1'b1);
        start = 1'b0;
        chk("t6.we",   32'(if_a.imem_we), 32'd0);
        chk("t6.ww",   32'(ww_a), 32'd0);
        chk("t6.err",  32'(err_a), 32'd0);
        chk("t6.busy", 32'(busy_a), 32'd1);

        // Overflow on the depth-4 instance
        for (int i = 0; i < 4; i++) begin
            addi(32'd5, 1'b0);
            chk("t7.b.we",   32'(if_b.imem_we), 32'd1);
            chk("t7.b.addr", if_b.imem_addr, 32'(4 * i));
        end
        addi(32'd5, 1'b0);
        chk("t7.b5.we",    32'(if_b.imem_we), 32'd0);
        chk("t7.b5.err",   32'(err_b), 32'd1);
        chk("t7.b5.errc",  32'(errc_b), 32'd1);
        chk("t7.b5.done",  32'(done_b), 32'd1);
        chk("t7.b5.busy",  32'(busy_b), 32'd0);
        chk("t7.b5.ready", 32'(if_b.in_ready), 32'd0);
        chk("t7.b5.ww",    32'(ww_b), 32'd4);
        chk_write_a("t7.a5", 32'd16, 32'h0050_0093);
        chk("t7.a5.err", 32'(err_a), 32'd0);

        // Reset mid-stream
        pulse_start();
        addi(32'd5, 1'b0);
        addi(32'd5, 1'b0);
        chk("t8.ww.pre", 32'(ww_a), 32'd2);
        rst_n = 1'b0;
        addi(32'd5, 1'b0);
        chk("t8.rst.we",    32'(if_a.imem_we), 32'd0);
        chk("t8.rst.addr",  if_a.imem_addr, 32'd0);
        chk("t8.rst.ww",    32'(ww_a), 32'd0);
        chk("t8.rst.busy",  32'(busy_a), 32'd0);
        rst_n = 1'b1;
        idle_cycle();
        pulse_start();
        chk("t8.ww",  32'(ww_a), 32'd0);
        chk("t8.err", 32'(err_a), 32'd0);
        addi(32'd5, 1'b1);
        chk_write_a("t8.addi", 32'd0, 32'h0050_0093);
        chk("t8.ww.post", 32'(ww_a), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
